// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding and fetch constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0
  localparam int unsigned PC_INC    = 4;

  // A redirect target whose low bits are set cannot be a legal word address.
  function automatic logic is_misaligned(input logic [1:0] lo);
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: reset value, +4 advance, redirect with word alignment.
module fetch_pc_reg
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              redir,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic [ADDR_W-1:0] pc
);

  // Redirect wins over the increment; low two bits are forced to zero.
  // The add wraps naturally at the register width.
  always_ff @(posedge clk) begin
    if (rst)        pc <= RESET_PC;
    else if (redir) pc <= {redir_pc[ADDR_W-1:2], 2'b00};
    else if (inc)   pc <= pc + ADDR_W'(PC_INC);
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: one-outstanding imem reads, instruction register with
// valid/ready toward decode, and redirect handling with in-flight kill.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_misalign
);

  fetch_state_e      state;
  logic              kill;      // response of the in-flight request must be dropped
  logic              pc_inc;
  logic [ADDR_W-1:0] pc;

  // Advance only when a live (non-killed, non-redirected) word is captured.
  assign pc_inc = (state == S_WAIT) && imem_rvalid && !kill && !redirect_valid;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (ADDR_W'(RESET_PC))
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .inc      (pc_inc),
    .redir    (redirect_valid),
    .redir_pc (redirect_pc),
    .pc       (pc)
  );

  assign imem_addr = pc;

  // Fetch FSM with registered request, instruction register and sticky flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_BOOT;
      imem_req       <= 1'b0;
      instr_valid    <= 1'b0;
      instr          <= NOP_INSTR;
      instr_pc       <= '0;
      kill           <= 1'b0;
      instr_misalign <= 1'b0;
    end else begin
      if (redirect_valid && is_misaligned(redirect_pc[1:0]))
        instr_misalign <= 1'b1;

      case (state)
        S_BOOT: begin
          state    <= S_REQ;
          imem_req <= 1'b1;
        end

        S_REQ: begin
          // A granted request is in flight whether or not we redirect;
          // on redirect its data is marked for dropping.
          if (imem_gnt) begin
            state    <= S_WAIT;
            imem_req <= 1'b0;
            if (redirect_valid) kill <= 1'b1;
          end
        end

        S_WAIT: begin
          if (redirect_valid) begin
            if (imem_rvalid) begin
              kill     <= 1'b0;
              state    <= S_REQ;
              imem_req <= 1'b1;
            end else begin
              kill <= 1'b1;
            end
          end else if (imem_rvalid) begin
            if (kill) begin
              kill     <= 1'b0;
              state    <= S_REQ;
              imem_req <= 1'b1;
            end else begin
              instr       <= imem_rdata;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              state       <= S_HOLD;
            end
          end
        end

        S_HOLD: begin
          // Redirect squashes the held word even if it is being accepted.
          if (redirect_valid || instr_ready) begin
            instr_valid <= 1'b0;
            state       <= S_REQ;
            imem_req    <= 1'b1;
          end
        end

        default: begin
          state    <= S_BOOT;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed scenarios push expected
// deliveries; a monitor pops and compares on each accepted instruction.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_misalign;

  int nchk = 0;
  int nerr = 0;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
  } exp_t;
  exp_t q[$];

  logic        mem_auto = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0), .ADDR_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_misalign (instr_misalign)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a);
    exp_t e;
    e.ins = mem_word(a);
    e.pc  = a;
    q.push_back(e);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!instr_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, instr_valid}, 32'd1);
  endtask

  // One-cycle accept; returns at the negedge after the accepting edge.
  task automatic accept();
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
  endtask

  // Zero-wait memory: grant whenever requested, data one cycle later.
  initial forever begin
    @(negedge clk);
    #1;
    if (mem_auto) begin
      imem_rvalid = 1'b0;
      if (pend) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        pend        = 1'b0;
      end
      imem_gnt = imem_req;
      if (imem_req) begin
        pend      = 1'b1;
        pend_addr = imem_addr;
      end
    end
  end

  // Monitor: every accepted, non-squashed instruction is checked in order.
  initial forever begin
    @(negedge clk);
    #2;
    if (instr_valid && instr_ready && !redirect_valid) begin
      if (q.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL unexpected_delivery: got pc %h instr %h expected none", instr_pc, instr);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("deliv_instr", instr, e.ins);
        chk("deliv_pc", instr_pc, e.pc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] h_instr, h_pc;
    rst = 1'b1;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req",      {31'd0, imem_req}, 32'd0);
    chk("rst_valid",    {31'd0, instr_valid}, 32'd0);
    chk("rst_instr",    instr, 32'h0000_0013);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_misalign", {31'd0, instr_misalign}, 32'd0);
    chk("rst_addr",     imem_addr, 32'h0);

    // 1: first fetch with zero-wait memory
    rst = 1'b0;
    mem_auto = 1'b1;
    push(32'h0);
    lat = 0;
    while (!instr_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("first_latency", lat, 32'd3);
    chk("first_instr", instr, 32'h0050_0093);
    chk("next_addr", imem_addr, 32'h4);

    // 2: hold with instr_ready low
    h_instr = instr;
    h_pc    = instr_pc;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_instr", instr, h_instr);
      chk("hold_pc", instr_pc, h_pc);
      chk("hold_req", {31'd0, imem_req}, 32'd0);
      chk("hold_valid", {31'd0, instr_valid}, 32'd1);
    end
    accept();

    // 3: redirect in S_WAIT, stale data arrives two cycles later
    mem_auto = 1'b0;
    chk("t3_req_addr", imem_addr, 32'h4);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("t3_valid", {31'd0, instr_valid}, 32'd0);
    chk("t3_req", {31'd0, imem_req}, 32'd1);
    chk("t3_addr", imem_addr, 32'h100);
    push(32'h100);
    mem_auto = 1'b1;
    wait_valid("t3_wait");
    accept();

    // 4: redirect in S_HOLD together with instr_ready
    wait_valid("t4_wait");
    chk("t4_held_pc", instr_pc, 32'h104);
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    chk("t4_squash", {31'd0, instr_valid}, 32'd0);
    chk("t4_addr", imem_addr, 32'h200);
    push(32'h200);
    wait_valid("t4_wait2");
    accept();

    // 5: misaligned redirect
    wait_valid("t5_wait");
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t5_addr", imem_addr, 32'h100);
    chk("t5_misalign", {31'd0, instr_misalign}, 32'd1);
    push(32'h100);
    wait_valid("t5_wait2");
    accept();

    // Redirect in S_REQ coincident with grant, plus PC wrap
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    push(32'hFFFF_FFFC);
    wait_valid("wrap_wait");
    accept();
    chk("wrap_addr", imem_addr, 32'h0);
    push(32'h0);
    wait_valid("wrap_wait2");
    accept();
    chk("misalign_sticky", {31'd0, instr_misalign}, 32'd1);

    // 6: reset while in S_WAIT, stale rvalid right after reset
    mem_auto = 1'b0;
    chk("t6_addr", imem_addr, 32'h4);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_misalign", {31'd0, instr_misalign}, 32'd0);
    chk("t6_valid", {31'd0, instr_valid}, 32'd0);
    chk("t6_instr", instr, 32'h0000_0013);
    chk("t6_addr_rst", imem_addr, 32'h0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0BAD_0BAD;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("t6_valid2", {31'd0, instr_valid}, 32'd0);
    push(32'h0);
    mem_auto = 1'b1;
    wait_valid("t6_wait");
    accept();

    repeat (2) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
